mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared memory bus.
// One transaction at a time; stalled transfers abort after TIMEOUT not-ready cycles.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// XFER  | owner's payload driven on the bus, waiting for bus_ready or timeout
// RESP  | done/err pulse to the owner; requests ignored for this cycle
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,

  output logic          bus_valid,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ready
);

  // A zero-width counter is illegal, so TIMEOUT=0 still keeps one bit.
  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          pick;
  logic          timed_out;
  logic          finish;
  logic [CW-1:0] tcnt;
  logic [DW-1:0] cap_data;

  // pick: 0 selects master 0, 1 selects master 1.
  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) begin
      pick = ~last_owner;
    end
  end

  // A ready in the same cycle as the limit wins: timed_out requires !bus_ready.
  assign timed_out = (TIMEOUT > 0) && !bus_ready && (tcnt == TLAST);
  assign finish    = bus_ready || timed_out;
  assign cap_data  = (bus_ready && !bus_we) ? bus_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      tcnt       <= '0;
      m0_gnt     <= 1'b0;
      m0_done    <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_gnt     <= 1'b0;
      m1_done    <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      m0_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_done <= 1'b0;
      m1_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner      <= pick;
            last_owner <= pick;
            bus_valid  <= 1'b1;
            bus_we     <= pick ? m1_we    : m0_we;
            bus_addr   <= pick ? m1_addr  : m0_addr;
            bus_wdata  <= pick ? m1_wdata : m0_wdata;
            m0_gnt     <= ~pick;
            m1_gnt     <= pick;
            tcnt       <= '0;
            state      <= XFER;
          end
        end

        XFER: begin
          if (finish) begin
            bus_valid <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_err   <= ~bus_ready;
              m1_rdata <= cap_data;
            end else begin
              m0_done  <= 1'b1;
              m0_err   <= ~bus_ready;
              m0_rdata <= cap_data;
            end
            state <= RESP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
